// File: rtl/obi_block_reader.sv
// obi_block_reader: reads a block of consecutive 32-bit words over OBI and
// streams them out through a valid/ready interface. Request issue is limited
// by a credit scheme: in-flight reads plus words waiting in the response
// buffer never exceed MAX_OUTSTANDING, so the buffer cannot overflow.
module obi_block_reader #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [3:0]            obi_be_o,
    output logic [DATA_WIDTH-1:0] obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0] obi_rdata_i,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]        CREDIT_LIMIT = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK    = {{(ADDR_WIDTH - 2){1'b1}}, 2'b00};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                  state_r;
    state_e                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [LEN_WIDTH-1:0]    issued_r;
    logic [LEN_WIDTH-1:0]    popped_r;
    logic [CNT_W-1:0]        outstanding_r;
    logic [DATA_WIDTH-1:0]   fifo_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    done_r;

    logic                    busy_s;
    logic                    credit_ok_s;
    logic                    req_s;
    logic                    grant_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    start_ok_s;
    logic                    start_zero_s;
    logic                    last_pop_s;

    assign busy_s       = (state_r == ST_BUSY);
    assign credit_ok_s  = (({1'b0, outstanding_r} + {1'b0, count_r}) < CREDIT_LIMIT);
    assign req_s        = busy_s && (issued_r < len_r) && credit_ok_s;
    assign grant_s      = req_s && obi_gnt_i;
    // A response with nothing in flight is spurious and is dropped.
    assign push_s       = obi_rvalid_i && (outstanding_r != {CNT_W{1'b0}});
    assign pop_s        = (count_r != {CNT_W{1'b0}}) && data_ready_i;
    assign start_ok_s   = !busy_s && start_i && (len_i != {LEN_WIDTH{1'b0}});
    assign start_zero_s = !busy_s && start_i && (len_i == {LEN_WIDTH{1'b0}});
    assign last_pop_s   = busy_s && pop_s && (popped_r == (len_r - LEN_WIDTH'(1)));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: enter BUSY on a non-empty command, leave on the last pop.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_pop_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Command latch and request address/issue tracking; address only moves on grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_r   <= {ADDR_WIDTH{1'b0}};
            len_r    <= {LEN_WIDTH{1'b0}};
            issued_r <= {LEN_WIDTH{1'b0}};
        end else if (start_ok_s) begin
            addr_r   <= base_addr_i & WORD_MASK;
            len_r    <= len_i;
            issued_r <= {LEN_WIDTH{1'b0}};
        end else if (grant_s) begin
            addr_r   <= addr_r + ADDR_WIDTH'(4);
            issued_r <= issued_r + LEN_WIDTH'(1);
        end
    end

    // Count of words delivered on the stream for the current command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            popped_r <= {LEN_WIDTH{1'b0}};
        end else if (start_ok_s) begin
            popped_r <= {LEN_WIDTH{1'b0}};
        end else if (busy_s && pop_s) begin
            popped_r <= popped_r + LEN_WIDTH'(1);
        end
    end

    // In-flight read counter; grant and response in one cycle cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({grant_s, push_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Response buffer storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= obi_rdata_i;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Response buffer occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Completion pulse: after the last pop, or right after a zero-length command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_pop_s || start_zero_s;
        end
    end

    assign busy_o       = busy_s;
    assign done_o       = done_r;
    assign obi_req_o    = req_s;
    assign obi_addr_o   = addr_r;
    assign obi_we_o     = 1'b0;
    assign obi_be_o     = 4'b1111;
    assign obi_wdata_o  = {DATA_WIDTH{1'b0}};
    assign data_valid_o = (count_r != {CNT_W{1'b0}});
    assign data_o       = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_obi_block_reader.sv
// Directed bench for obi_block_reader with a behavioural OBI memory and
// stream sink; expected addresses/data are computed from command base/length.
`timescale 1ns/1ps
module tb_obi_block_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = 32'h0;
    logic [15:0] len = 16'h0;
    logic        busy, done_o, obi_req, obi_we, dvalid;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] obi_addr, obi_wdata, data;
    logic [3:0]  obi_be;
    logic        ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int gnt_delay = 0;
    int done_cnt = 0;
    int stab_err = 0;
    int cyc = 0;
    int wcnt = 0;
    logic [31:0] grant_q[$];
    int          gcyc_q[$];
    logic [31:0] pop_q[$];

    always #5 clk = ~clk;

    obi_block_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_addr_i  (base),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done_o),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (gnt),
        .obi_addr_o   (obi_addr),
        .obi_we_o     (obi_we),
        .obi_be_o     (obi_be),
        .obi_wdata_o  (obi_wdata),
        .obi_rvalid_i (rvalid),
        .obi_rdata_i  (rdata),
        .data_valid_o (dvalid),
        .data_ready_i (ready),
        .data_o       (data)
    );

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // OBI memory model, stream sink and request-stability monitor.
    always @(posedge clk) begin
        logic        rst_pre, req_pre, g_pre, p_pre;
        logic [31:0] a_pre, d_pre;
        rst_pre = rst_n;
        req_pre = rst_n && obi_req;
        g_pre   = rst_n && obi_req && gnt;
        a_pre   = obi_addr;
        p_pre   = rst_n && dvalid && ready;
        d_pre   = data;
        #1;
        cyc++;
        if (g_pre) begin
            grant_q.push_back(a_pre);
            gcyc_q.push_back(cyc);
        end
        if (p_pre) pop_q.push_back(d_pre);
        if (done_o) done_cnt++;
        if (rst_n && rst_pre && req_pre && !g_pre && (!obi_req || obi_addr != a_pre)) stab_err++;
        rvalid = g_pre && rst_n;
        rdata  = g_pre ? rd_word(a_pre) : 32'h0;
        if (g_pre) wcnt = 0;
        else if (req_pre) wcnt++;
        gnt = (gnt_delay == 0) ? 1'b1 : (wcnt >= gnt_delay);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        grant_q.delete();
        gcyc_q.delete();
        pop_q.delete();
        done_cnt = 0;
        stab_err = 0;
    endtask

    task automatic start_cmd(input logic [31:0] b, input logic [15:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (done_o) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_idle_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_seq(input string tag, input logic [31:0] b, input int n);
        logic [31:0] a;
        check({tag, "_grant_count"}, 64'(grant_q.size()), 64'(n));
        check({tag, "_word_count"}, 64'(pop_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = b + 32'(4 * i);
            if (i < grant_q.size()) check($sformatf("%s_addr%0d", tag, i), 64'(grant_q[i]), 64'(a));
            if (i < pop_q.size())   check($sformatf("%s_data%0d", tag, i), 64'(pop_q[i]), 64'(rd_word(a)));
        end
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=no_finish expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_req", 64'(obi_req), 64'd0);
        check("rst_dvalid", 64'(dvalid), 64'd0);
        check("rst_addr", 64'(obi_addr), 64'd0);
        check("const_we", 64'(obi_we), 64'd0);
        check("const_be", 64'(obi_be), 64'hF);
        check("const_wdata", 64'(obi_wdata), 64'd0);
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);

        // Basic 4-word read, grant and ready always high
        clear_log();
        start_cmd(32'h100, 16'd4);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_first_req", 64'(obi_req), 64'd1);
        check("t1_first_addr", 64'(obi_addr), 64'h100);
        wait_done("t1", 40);
        check_seq("t1", 32'h100, 4);
        if (gcyc_q.size() == 4) check("t1_b2b_grants", 64'(gcyc_q[3] - gcyc_q[0]), 64'd3);

        // Zero-length command
        clear_log();
        start_cmd(32'h200, 16'd0);
        check("t2_done", 64'(done_o), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);
        check("t2_req", 64'(obi_req), 64'd0);
        @(negedge clk);
        check("t2_done_clear", 64'(done_o), 64'd0);
        check("t2_no_grant", 64'(grant_q.size()), 64'd0);
        check("t2_done_pulses", 64'(done_cnt), 64'd1);

        // Stream back-pressure: credit limit stops requests at 4
        clear_log();
        ready = 1'b0;
        start_cmd(32'h400, 16'd8);
        repeat (12) @(negedge clk);
        check("t3_stall_grants", 64'(grant_q.size()), 64'd4);
        check("t3_stall_req", 64'(obi_req), 64'd0);
        check("t3_stall_dvalid", 64'(dvalid), 64'd1);
        check("t3_stall_busy", 64'(busy), 64'd1);
        check("t3_stall_data", 64'(data), 64'(rd_word(32'h400)));
        @(negedge clk);
        check("t3_stall_data_hold", 64'(data), 64'(rd_word(32'h400)));
        ready = 1'b1;
        wait_done("t3", 60);
        check_seq("t3", 32'h400, 8);

        // Slow grant plus an ignored start while busy
        clear_log();
        gnt_delay = 3;
        @(negedge clk);
        start_cmd(32'h800, 16'd3);
        repeat (2) @(negedge clk);
        start = 1'b1;
        base  = 32'h1000;
        len   = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", 100);
        gnt_delay = 0;
        check_seq("t4", 32'h800, 3);
        check("t4_req_stable", 64'(stab_err), 64'd0);
        if (gcyc_q.size() >= 2) check("t4_grant_spacing", 64'(gcyc_q[1] - gcyc_q[0]), 64'd4);
        @(negedge clk);

        // Address wrap at the top of the address space
        clear_log();
        start_cmd(32'hFFFF_FFF8, 16'd3);
        wait_done("t5", 40);
        check_seq("t5", 32'hFFFF_FFF8, 3);

        // Reset in the middle of a command, then a fresh command
        clear_log();
        start_cmd(32'h2000, 16'd6);
        for (int i = 0; i < 20 && grant_q.size() < 2; i++) @(negedge clk);
        check("t6_grants_before_rst", 64'(grant_q.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done_o), 64'd0);
        check("t6_rst_req", 64'(obi_req), 64'd0);
        check("t6_rst_dvalid", 64'(dvalid), 64'd0);
        check("t6_rst_addr", 64'(obi_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        start_cmd(32'h3000, 16'd2);
        wait_done("t6", 40);
        check_seq("t6", 32'h3000, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obi_block_reader.md
OBI_BLOCK_READER -- requirements
Module: obi_block_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, OBI byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, OBI data and stream width; fixed at 32.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, word-count field width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, credit limit and response-buffer depth; power of two, 2..16.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start_i  input  1  one-cycle command strobe.
REQ-008 SHALL have port base_addr_i  input  ADDR_WIDTH  first byte address; bits [1:0] ignored and treated as 0.
REQ-009 SHALL have port len_i  input  LEN_WIDTH  number of 32-bit words to read.
REQ-010 SHALL have port busy_o  output  1  command in progress.
REQ-011 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port obi_req_o  output  1  OBI request.
REQ-013 SHALL have port obi_gnt_i  input  1  OBI grant.
REQ-014 SHALL have port obi_addr_o  output  ADDR_WIDTH  OBI address.
REQ-015 SHALL have port obi_we_o  output  1  OBI write enable; constant 0.
REQ-016 SHALL have port obi_be_o  output  4  OBI byte enables; constant 4'b1111.
REQ-017 SHALL have port obi_wdata_o  output  DATA_WIDTH  OBI write data; constant 0.
REQ-018 SHALL have port obi_rvalid_i  input  1  OBI response valid.
REQ-019 SHALL have port obi_rdata_i  input  DATA_WIDTH  OBI read data.
REQ-020 SHALL have port data_valid_o  output  1  stream valid.
REQ-021 SHALL have port data_ready_i  input  1  stream ready.
REQ-022 SHALL have port data_o  output  DATA_WIDTH  stream data.

Function
REQ-023 SHALL implement FSM IDLE -> BUSY -> IDLE; busy_o = (state==BUSY).
REQ-024 In IDLE, start_i with len_i!=0 SHALL latch address/length and enter BUSY next cycle; start_i in BUSY SHALL be ignored.
REQ-025 start_i with len_i==0 SHALL issue no request, stay IDLE, and pulse done_o the following cycle.
REQ-026 In BUSY, obi_req_o SHALL assert when requests_issued < len and (outstanding + buffer occupancy) < MAX_OUTSTANDING.
REQ-027 Once obi_req_o is high, obi_req_o and obi_addr_o SHALL hold stable until the cycle obi_gnt_i is sampled high.
REQ-028 Each granted request SHALL advance obi_addr_o by 4, wrapping modulo 2^ADDR_WIDTH; first request latency after start_i is 1 cycle.
REQ-029 Back-to-back grants SHALL sustain one request per cycle while credit remains.
REQ-030 Responses SHALL be taken in order, one per obi_rvalid_i, earliest the cycle after grant, and written to a MAX_OUTSTANDING-deep FIFO.
REQ-031 Grant and rvalid in the same cycle SHALL update the outstanding counter by net zero.
REQ-032 FIFO SHALL never overflow by construction of REQ-026; obi_rvalid_i with zero outstanding SHALL be dropped.
REQ-033 data_valid_o = FIFO non-empty; data_o = FIFO head; pop on data_valid_o & data_ready_i; simultaneous push and pop when full or empty SHALL be legal.
REQ-034 data_o SHALL hold stable while data_valid_o is high and data_ready_i is low.
REQ-035 When the len-th word is popped, done_o SHALL pulse the next cycle and FSM SHALL return to IDLE in that same cycle.

Reset
REQ-036 On rst_ni low, asynchronously: state IDLE, all counters and FIFO pointers 0; busy_o, done_o, obi_req_o, data_valid_o 0; obi_addr_o 0.
REQ-037 Reset mid-command SHALL abandon the command; bench shall not deliver responses for pre-reset grants after reset release.

Verification
REQ-038 base 0x100, len 4, gnt and ready tied 1, rvalid one cycle after gnt -> addresses 0x100,0x104,0x108,0x10C on consecutive cycles, 4 words out in order, done_o once.
REQ-039 len 8, data_ready_i held 0 -> exactly 4 grants then obi_req_o low; releasing ready resumes requests; all 8 words delivered.
REQ-040 obi_gnt_i delayed 3 cycles per request -> obi_addr_o stable while waiting, no duplicate or skipped address.
REQ-041 len 0 -> no obi_req_o, done_o one cycle after start_i; start_i during BUSY -> no effect on address sequence.
REQ-042 base 0xFFFFFFF8, len 3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-043 rst_ni low after 2 grants of len 6 -> all outputs 0 immediately; new command of len 2 completes normally.
